// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package mod_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Gray code of a value up to 32 bits wide; callers truncate to their WIDTH.
    function automatic logic [31:0] gray_code(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: load/clamp, increment/decrement with modulo wrap.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next_c,
    output logic             wrap_c,
    output logic             load_err_c
);

    // One extra bit so MODULUS = 2**WIDTH is representable and compares stay exact.
    localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST_X = MOD_X - (WIDTH+1)'(1);

    logic [WIDTH:0] q_x;
    logic [WIDTH:0] load_x;
    logic [WIDTH:0] inc_x;
    logic [WIDTH:0] dec_x;

    always_comb begin
        q_next_c   = q;
        wrap_c     = 1'b0;
        load_err_c = 1'b0;
        q_x        = {1'b0, q};
        load_x     = {1'b0, load_val};
        inc_x      = q_x + (WIDTH+1)'(1);
        dec_x      = q_x - (WIDTH+1)'(1);

        if (load) begin
            if (load_x >= MOD_X) begin
                q_next_c   = LAST_X[WIDTH-1:0];
                load_err_c = 1'b1;
            end else begin
                q_next_c = load_val;
            end
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (inc_x >= MOD_X) begin
                    q_next_c = '0;
                    wrap_c   = 1'b1;
                end else begin
                    q_next_c = inc_x[WIDTH-1:0];
                end
            end else begin
                // Borrow out of the extended difference marks the underflow from 0.
                if (dec_x[WIDTH]) begin
                    q_next_c = LAST_X[WIDTH-1:0];
                    wrap_c   = 1'b1;
                end else begin
                    q_next_c = dec_x[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-N up/down counter with load, cascade tc and wrap/load-error pulses.
// Optional registered Gray output q_gray when MOD_COUNTER_GRAY_EN is defined.
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
`ifdef MOD_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] q_next_c;
    logic             wrap_c;
    logic             load_err_c;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q          (q),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .q_next_c   (q_next_c),
        .wrap_c     (wrap_c),
        .load_err_c (load_err_c)
    );

    // Zero-latency terminal count so a downstream stage can use it as its enable.
    assign tc = en & ~load & ((up_dn == DIR_UP) ? (q == LAST) : (q == '0));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_next_c;
            wrap     <= wrap_c;
            load_err <= load_err_c;
        end
    end

`ifdef MOD_COUNTER_GRAY_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q_gray <= '0;
        end else begin
            q_gray <= WIDTH'(gray_code(32'(q_next_c)));
        end
    end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: directed vectors, cascade pair, full-range sweep.
module tb_mod_updown_counter;
    import mod_counter_pkg::*;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    // Main instance, MODULUS=10
    logic       m_en, m_up, m_load;
    logic [3:0] m_lv, m_q;
    logic       m_tc, m_wrap, m_lerr;
    // Cascade pair, MODULUS=10 each
    logic       c_en, c_up, c_load;
    logic [3:0] c_lv, lo_q, hi_q;
    logic       lo_tc, lo_wrap, lo_lerr, hi_tc, hi_wrap, hi_lerr;
    // Full binary range instance, MODULUS=16
    logic       f_en;
    logic [3:0] f_q;
    logic       f_tc, f_wrap, f_lerr;
`ifdef MOD_COUNTER_GRAY_EN
    logic [3:0] m_qg, lo_qg, hi_qg, f_qg, prev_g;
`endif

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clock(clock), .clear(clear), .en(m_en), .up_dn(m_up), .load(m_load),
        .load_val(m_lv), .q(m_q), .tc(m_tc), .wrap(m_wrap), .load_err(m_lerr)
`ifdef MOD_COUNTER_GRAY_EN
        , .q_gray(m_qg)
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clock(clock), .clear(clear), .en(c_en), .up_dn(c_up), .load(c_load),
        .load_val(c_lv), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_lerr)
`ifdef MOD_COUNTER_GRAY_EN
        , .q_gray(lo_qg)
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clock(clock), .clear(clear), .en(lo_tc), .up_dn(c_up), .load(c_load),
        .load_val(c_lv), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_lerr)
`ifdef MOD_COUNTER_GRAY_EN
        , .q_gray(hi_qg)
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_full (
        .clock(clock), .clear(clear), .en(f_en), .up_dn(c_up), .load(c_load),
        .load_val(c_lv), .q(f_q), .tc(f_tc), .wrap(f_wrap), .load_err(f_lerr)
`ifdef MOD_COUNTER_GRAY_EN
        , .q_gray(f_qg)
`endif
    );

    typedef struct {
        int       which;
        logic [7:0] q;
        logic     wrap;
        logic     lerr;
        logic     tc;
        string    name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   hi_wraps = 0;
    int   lo_wraps = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int which, input logic [7:0] q, input logic w, input logic l,
                        input logic t, input string nm);
        exp_t e;
        e.which = which; e.q = q; e.wrap = w; e.lerr = l; e.tc = t; e.name = nm;
        sb.push_back(e);
    endtask

    // Drive main-instance inputs for the next edge and queue the expected post-edge view.
    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lv,
                        input logic [3:0] eq, input logic ew, input logic el, input logic et,
                        input string nm);
        @(negedge clock);
        m_en = e; m_up = u; m_load = l; m_lv = lv;
        push(0, 8'(eq), ew, el, et, nm);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            case (cur.which)
                0: begin
                    check({cur.name, ".q"},    32'(m_q),    32'(cur.q[3:0]));
                    check({cur.name, ".wrap"}, 32'(m_wrap), 32'(cur.wrap));
                    check({cur.name, ".lerr"}, 32'(m_lerr), 32'(cur.lerr));
                    check({cur.name, ".tc"},   32'(m_tc),   32'(cur.tc));
                end
                1: check({cur.name, ".hilo"}, 32'({hi_q, lo_q}), 32'(cur.q));
                default: begin
                    check({cur.name, ".q"},    32'(f_q),    32'(cur.q[3:0]));
                    check({cur.name, ".wrap"}, 32'(f_wrap), 32'(cur.wrap));
                    check({cur.name, ".tc"},   32'(f_tc),   32'(cur.tc));
`ifdef MOD_COUNTER_GRAY_EN
                    check({cur.name, ".gray"}, 32'(f_qg),
                          32'(cur.q[3:0] ^ (cur.q[3:0] >> 1)));
                    check({cur.name, ".gray1bit"}, 32'($countones(f_qg ^ prev_g)), 32'd1);
                    prev_g = f_qg;
`endif
                end
            endcase
        end
    end

    always @(posedge clock) begin
        #1;
        if (hi_wrap) hi_wraps++;
        if (lo_wrap) lo_wraps++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1;
        m_en = 0; m_up = 1; m_load = 0; m_lv = 0;
        c_en = 0; c_up = 1; c_load = 0; c_lv = 0; f_en = 0;
`ifdef MOD_COUNTER_GRAY_EN
        prev_g = 4'd0;
`endif
        #2;
        check("rst.q",    32'(m_q),    32'd0);
        check("rst.wrap", 32'(m_wrap), 32'd0);
        check("rst.lerr", 32'(m_lerr), 32'd0);
`ifdef MOD_COUNTER_GRAY_EN
        check("rst.gray", 32'(f_qg), 32'd0);
`endif
        @(negedge clock);
        clear = 1'b0;

        // Up count through the modulus
        for (int n = 1; n <= 12; n++)
            step(1, 1, 0, 0, 4'(n % 10), n == 10, 0, n == 9, "up");

        // Load beats en; direction change keeps continuity
        step(1, 1, 1, 5, 5, 0, 0, 0, "ld5en");
        step(1, 1, 0, 0, 6, 0, 0, 0, "cont_up");
        step(1, 0, 0, 0, 5, 0, 0, 0, "cont_dn");

        // Load 3 then count down across zero
        step(0, 0, 1, 3, 3, 0, 0, 0, "ld3");
        step(1, 0, 0, 0, 2, 0, 0, 0, "dn2");
        step(1, 0, 0, 0, 1, 0, 0, 0, "dn1");
        step(1, 0, 0, 0, 0, 0, 0, 1, "dn0");
        step(1, 0, 0, 0, 9, 1, 0, 0, "dn9");
        step(1, 0, 0, 0, 8, 0, 0, 0, "dn8");

        // Out-of-range loads clamp to MODULUS-1
        step(1, 1, 1, 12, 9, 0, 1, 0, "ld12");
        step(0, 1, 0, 0,  9, 0, 0, 0, "hold9");
        step(1, 1, 0, 0,  0, 1, 0, 0, "wrap_up");
        step(0, 1, 1, 9,  9, 0, 0, 0, "ld9");
        step(0, 1, 1, 10, 9, 0, 1, 0, "ld10");
        step(0, 1, 1, 15, 9, 0, 1, 0, "ld15");
        step(0, 0, 1, 0,  0, 0, 0, 0, "ld0");
        step(0, 0, 0, 0,  0, 0, 0, 0, "hold0");
        step(0, 1, 1, 7,  7, 0, 0, 0, "ld7");

        // Asynchronous clear between edges, then held across an edge with load/en pending
        @(posedge clock);
        #3;
        clear = 1'b1;
        #1;
        check("aclr.q",    32'(m_q),    32'd0);
        check("aclr.wrap", 32'(m_wrap), 32'd0);
        check("aclr.lerr", 32'(m_lerr), 32'd0);
        m_en = 1; m_up = 1; m_load = 1; m_lv = 5;
        @(posedge clock);
        #1;
        check("clr_hold.q", 32'(m_q), 32'd0);
        @(negedge clock);
        clear = 1'b0;
        m_load = 0;
        push(0, 8'd1, 0, 0, 0, "post_clr");

        // Cascade: hi.en = lo.tc, 100 clocks up
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            m_en = 0;
            c_en = 1;
            push(1, {4'((n % 100) / 10), 4'(n % 10)}, 0, 0, 0, "casc");
        end
        @(negedge clock);
        c_en = 0;

        // Full binary range sweep, including 15 -> 0 rollover
        for (int n = 1; n <= 17; n++) begin
            @(negedge clock);
            f_en = 1;
            push(2, 8'(n % 16), n == 16, 0, (n % 16) == 15, "full");
        end
        @(negedge clock);
        f_en = 0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
        #2;
        check("drain", 32'(sb.size()), 32'd0);
        check("casc.hi_wraps", 32'(hi_wraps), 32'd1);
        check("casc.lo_wraps", 32'(lo_wraps), 32'd10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
